// File: rtl/capture_readout_pkg.sv
// Shared state encoding, default header bytes and sample packing for capture_readout.
// Latency: none (declarations only).  Backpressure: n/a.
package capture_readout_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE     = 4'd0;
    localparam state_t ST_HDR      = 4'd1;
    localparam state_t ST_RD       = 4'd2;
    localparam state_t ST_LATCH    = 4'd3;
    localparam state_t ST_TX_HI    = 4'd4;
    localparam state_t ST_TX_LO    = 4'd5;
    localparam state_t ST_TRL      = 4'd6;
    localparam state_t ST_REARM    = 4'd7;
    localparam state_t ST_WAIT_CLR = 4'd8;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

    // Sample arrives zero-extended to 16 bits, so the upper byte is already padded.
    function automatic logic [7:0] pack_hi(input logic [15:0] sample);
        return 8'(sample >> 8);
    endfunction

endpackage

// File: rtl/capture_readout_tx_stage.sv
// Output holding register for the host byte stream; keeps Tx_data/Tx_valid stable until accepted.
// Latency: byte visible the cycle after load_vld.  Backpressure: holds while Tx_ready=0;
// caller must only load when the register is empty or being accepted this cycle.
module readout_tx_stage (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       load_vld,
    input  logic [7:0] load_dat,
    input  logic       Tx_ready,
    output logic       Tx_valid,
    output logic [7:0] Tx_data,
    output logic       tx_acc
);

    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_vld) begin
            valid_d = 1'b1;
            data_d  = load_dat;
        end else if (valid_q && Tx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign Tx_valid = valid_q;
    assign Tx_data  = data_q;
    assign tx_acc   = valid_q && Tx_ready;

endmodule

// File: rtl/capture_readout.sv
// Drains the ADC capture FIFO after capture-done and frames samples as HDR0 HDR1 {hi lo}* CNT_HI CNT_LO [CHK].
// Latency: first header byte valid the cycle after Cap_end is seen; +2 cycles per sample (read, latch).
// Backpressure: Tx_ready low stalls the frame, no FIFO reads while a byte waits. CHK byte only with READOUT_CHECKSUM_EN.
module capture_readout
    import capture_readout_pkg::*;
#(
    parameter int         DATA_W      = 10,
    parameter int         MAX_SAMPLES = 1024,
    parameter int         CNT_W       = 11,
    parameter logic [7:0] HDR0        = HDR0_DEF,
    parameter logic [7:0] HDR1        = HDR1_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Cap_end,
    input  logic              Fifo_empty,
    input  logic [DATA_W-1:0] Fifo_data,
    output logic              Fifo_rdreq,
    output logic              Cap_bg,
    output logic [7:0]        Tx_data,
    output logic              Tx_valid,
    input  logic              Tx_ready,
    output logic              Busy,
    output logic              Frame_done
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SAMPLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       samp_lo_q, samp_lo_d;
    logic [1:0]       idx_q, idx_d;
`ifdef READOUT_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    logic       tx_load;
    logic [7:0] tx_byte;
    logic       tx_acc;
    logic [15:0] cnt16;
    logic [15:0] samp16;

    always_comb begin
        cnt16 = 16'h0000;
        cnt16[CNT_W-1:0] = cnt_q;
        samp16 = 16'h0000;
        samp16[DATA_W-1:0] = Fifo_data;
    end

    assign Fifo_rdreq = (state_q == ST_RD) && !Fifo_empty && (cnt_q < MAX_CNT);
    assign Cap_bg     = (state_q == ST_REARM);
    assign Frame_done = (state_q == ST_REARM);
    assign Busy       = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        samp_lo_d = samp_lo_q;
        idx_d     = idx_q;
        tx_load   = 1'b0;
        tx_byte   = 8'h00;
`ifdef READOUT_CHECKSUM_EN
        chk_d     = chk_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (Cap_end) begin
                    state_d = ST_HDR;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    tx_load = 1'b1;
                    tx_byte = HDR0;
`ifdef READOUT_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                end
            end
            ST_HDR: begin
                if (tx_acc) begin
                    if (idx_q == 2'd0) begin
                        tx_load = 1'b1;
                        tx_byte = HDR1;
                        idx_d   = 2'd1;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (Fifo_rdreq) begin
                    state_d = ST_LATCH;
                end else begin
                    // Empty FIFO or sample limit closes the frame with the trailer.
                    state_d = ST_TRL;
                    idx_d   = 2'd0;
                    tx_load = 1'b1;
                    tx_byte = cnt16[15:8];
`ifdef READOUT_CHECKSUM_EN
                    chk_d   = chk_q + cnt16[15:8] + cnt16[7:0];
`endif
                end
            end
            ST_LATCH: begin
                samp_lo_d = samp16[7:0];
                cnt_d     = cnt_q + CNT_W'(1);
                tx_load   = 1'b1;
                tx_byte   = pack_hi(samp16);
                state_d   = ST_TX_HI;
`ifdef READOUT_CHECKSUM_EN
                chk_d     = chk_q + pack_hi(samp16) + samp16[7:0];
`endif
            end
            ST_TX_HI: begin
                if (tx_acc) begin
                    tx_load = 1'b1;
                    tx_byte = samp_lo_q;
                    state_d = ST_TX_LO;
                end
            end
            ST_TX_LO: begin
                if (tx_acc) begin
                    state_d = ST_RD;
                end
            end
            ST_TRL: begin
                if (tx_acc) begin
                    case (idx_q)
                        2'd0: begin
                            tx_load = 1'b1;
                            tx_byte = cnt16[7:0];
                            idx_d   = 2'd1;
                        end
                        2'd1: begin
`ifdef READOUT_CHECKSUM_EN
                            tx_load = 1'b1;
                            tx_byte = chk_q;
                            idx_d   = 2'd2;
`else
                            state_d = ST_REARM;
`endif
                        end
                        default: begin
                            state_d = ST_REARM;
                        end
                    endcase
                end
            end
            ST_REARM: begin
                state_d = ST_WAIT_CLR;
            end
            ST_WAIT_CLR: begin
                // A done level still held from this capture must not start another frame.
                if (!Cap_end) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            samp_lo_q <= 8'h00;
            idx_q     <= 2'd0;
`ifdef READOUT_CHECKSUM_EN
            chk_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            samp_lo_q <= samp_lo_d;
            idx_q     <= idx_d;
`ifdef READOUT_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    readout_tx_stage u_tx_stage (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load_vld (tx_load),
        .load_dat (tx_byte),
        .Tx_ready (Tx_ready),
        .Tx_valid (Tx_valid),
        .Tx_data  (Tx_data),
        .tx_acc   (tx_acc)
    );

endmodule

// File: tb/tb_capture_readout.sv
// Bench for capture_readout: FIFO emulator, byte-stream monitor and a frame-level reference model.
module tb_capture_readout;

    localparam int MAXS = 4;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Cap_end = 1'b0;
    logic       Fifo_empty;
    logic [9:0] Fifo_data = '0;
    logic       Fifo_rdreq;
    logic       Cap_bg;
    logic [7:0] Tx_data;
    logic       Tx_valid;
    logic       Tx_ready = 1'b0;
    logic       Busy;
    logic       Frame_done;

    capture_readout #(.DATA_W(10), .MAX_SAMPLES(MAXS), .CNT_W(3)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Cap_end(Cap_end), .Fifo_empty(Fifo_empty),
        .Fifo_data(Fifo_data), .Fifo_rdreq(Fifo_rdreq), .Cap_bg(Cap_bg),
        .Tx_data(Tx_data), .Tx_valid(Tx_valid), .Tx_ready(Tx_ready),
        .Busy(Busy), .Frame_done(Frame_done)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    // Capture FIFO emulator: q valid one cycle after rdreq, never flushed by reset.
    logic [9:0] mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign Fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge Clk) begin
        if (Fifo_rdreq && rd_ptr != wr_ptr) begin
            Fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic [7:0] rx_q [$];
    int rd_cnt = 0, bg_cnt = 0, fd_cnt = 0, stab_err = 0, empty_rd_err = 0;
    logic       prev_hold = 1'b0;
    logic [7:0] prev_dat = 8'h00;
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (prev_hold && (!Tx_valid || Tx_data != prev_dat)) stab_err++;
            if (Tx_valid && Tx_ready) rx_q.push_back(Tx_data);
            if (Fifo_rdreq) rd_cnt++;
            if (Fifo_rdreq && Fifo_empty) empty_rd_err++;
            if (Cap_bg) bg_cnt++;
            if (Frame_done) fd_cnt++;
            prev_hold = Tx_valid && !Tx_ready;
            prev_dat  = Tx_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Reference model: samples currently in the FIFO and the frame they should produce.
    logic [9:0] model_q [$];
    logic [7:0] exp_q [$];
    int exp_rd;

    task automatic push_sample(input logic [9:0] s);
        mem[wr_ptr] = s;
        wr_ptr++;
        model_q.push_back(s);
    endtask

    task automatic build_expected();
        int n;
        logic [7:0] sum;
        logic [9:0] s;
        exp_q = {};
        n = (model_q.size() < MAXS) ? model_q.size() : MAXS;
        exp_rd = n;
        sum = 8'h00;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        for (int i = 0; i < n; i++) begin
            s = model_q.pop_front();
            exp_q.push_back({6'b0, s[9:8]});
            exp_q.push_back(s[7:0]);
            sum = sum + {6'b0, s[9:8]} + s[7:0];
        end
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(n));
        sum = sum + 8'(n);
`ifdef READOUT_CHECKSUM_EN
        exp_q.push_back(sum);
`endif
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic finish_frame(input string name, input int ready_pct, input bit hold_cap,
                                input int rd0, input int bg0, input int fd0);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 500 && !done; c++) begin
            @(posedge Clk);
            #1;
            Tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (Busy && !hold_cap) Cap_end = 1'b0;
            if (fd_cnt != fd0) done = 1'b1;
        end
        Tx_ready = 1'b1;
        total++;
        if (!done) begin
            bad++;
            $display("FAIL %s_timeout frame_done not seen within budget", name);
        end
        total++;
        if (rx_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_len got=%0d exp=%0d", name, rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            total++;
            if (rx_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s_byte%0d got=%02h exp=%02h", name, i, rx_q[i], exp_q[i]);
            end
        end
        total++;
        if (rd_cnt - rd0 !== exp_rd) begin
            bad++;
            $display("FAIL %s_rdreq got=%0d exp=%0d", name, rd_cnt - rd0, exp_rd);
        end
        total++;
        if (bg_cnt - bg0 !== 1) begin
            bad++;
            $display("FAIL %s_cap_bg got=%0d exp=1", name, bg_cnt - bg0);
        end
        if (!hold_cap) begin
            for (int c = 0; c < 20 && Busy; c++) wait_cyc(1);
            total++;
            if (Busy !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy_end got=%b exp=0", name, Busy);
            end
        end
    endtask

    task automatic run_frame(input string name, input int ready_pct, input bit hold_cap);
        int rd0, bg0, fd0;
        build_expected();
        rx_q = {};
        rd0 = rd_cnt;
        bg0 = bg_cnt;
        fd0 = fd_cnt;
        Cap_end = 1'b1;
        finish_frame(name, ready_pct, hold_cap, rd0, bg0, fd0);
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({Fifo_rdreq, Cap_bg, Tx_valid, Busy, Frame_done} !== 5'b0) begin
            bad++;
            $display("FAIL %s_ctl got=%b%b%b%b%b exp=00000", name, Fifo_rdreq, Cap_bg, Tx_valid, Busy, Frame_done);
        end
        total++;
        if (Tx_data !== 8'h00) begin
            bad++;
            $display("FAIL %s_txdata got=%02h exp=00", name, Tx_data);
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check_outputs_zero("reset");
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        @(negedge Clk);
        check_outputs_zero("post_reset");
    endtask

    task automatic test_basic();
        push_sample(10'h3FF);
        push_sample(10'h000);
        push_sample(10'h155);
        Tx_ready = 1'b0;
        @(posedge Clk);
        #1 Cap_end = 1'b1;
        @(negedge Clk);
        total++;
        if (Tx_valid !== 1'b0) begin
            bad++;
            $display("FAIL lat_pre tx_valid got=%b exp=0", Tx_valid);
        end
        @(negedge Clk);
        total++;
        if (Tx_valid !== 1'b1 || Tx_data !== 8'hA5) begin
            bad++;
            $display("FAIL lat_first got=%b/%02h exp=1/a5", Tx_valid, Tx_data);
        end
        run_frame("basic", 100, 1'b0);
    endtask

    task automatic test_empty();
        run_frame("empty", 100, 1'b0);
    endtask

    task automatic test_max();
        for (int i = 0; i < 6; i++) push_sample(10'($urandom));
        run_frame("max", 100, 1'b0);
        total++;
        if (wr_ptr - rd_ptr !== model_q.size()) begin
            bad++;
            $display("FAIL max_left got=%0d exp=%0d", wr_ptr - rd_ptr, model_q.size());
        end
    endtask

    task automatic test_cap_hold();
        int fd0, rd0;
        run_frame("hold", 100, 1'b1);
        fd0 = fd_cnt;
        rd0 = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            total++;
            if (Busy !== 1'b1 || Tx_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold_wait%0d busy/valid got=%b/%b exp=1/0", i, Busy, Tx_valid);
            end
        end
        total++;
        if (fd_cnt != fd0 || rd_cnt != rd0) begin
            bad++;
            $display("FAIL hold_refire frame_done=%0d rdreq=%0d exp=0/0", fd_cnt - fd0, rd_cnt - rd0);
        end
        @(posedge Clk);
        #1 Cap_end = 1'b0;
        wait_cyc(2);
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_clear busy got=%b exp=0", Busy);
        end
        push_sample(10'h2C7);
        run_frame("rearm", 100, 1'b0);
    endtask

    task automatic test_backpressure();
        int rd0, bg0, fd0, rdhold;
        logic [7:0] d0;
        bit seen;
        push_sample(10'($urandom));
        push_sample(10'($urandom));
        build_expected();
        rx_q = {};
        rd0 = rd_cnt;
        bg0 = bg_cnt;
        fd0 = fd_cnt;
        Tx_ready = 1'b1;
        Cap_end = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(posedge Clk);
            #1;
            if (Busy) Cap_end = 1'b0;
            if (rx_q.size() == 3) begin
                Tx_ready = 1'b0;
                seen = 1'b1;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL bp_reach timeout waiting for low byte");
        end
        d0 = Tx_data;
        total++;
        if (d0 !== exp_q[3]) begin
            bad++;
            $display("FAIL bp_lo_byte got=%02h exp=%02h", d0, exp_q[3]);
        end
        rdhold = rd_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            total++;
            if (Tx_valid !== 1'b1 || Tx_data !== d0) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%02h exp=1/%02h", i, Tx_valid, Tx_data, d0);
            end
        end
        total++;
        if (rd_cnt != rdhold) begin
            bad++;
            $display("FAIL bp_rdreq got=%0d exp=0", rd_cnt - rdhold);
        end
        finish_frame("bp", 100, 1'b0, rd0, bg0, fd0);
    endtask

    task automatic test_reset_mid();
        int rd0;
        bit hit;
        for (int i = 0; i < 3; i++) push_sample(10'($urandom));
        rd0 = rd_cnt;
        Tx_ready = 1'b1;
        Cap_end = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge Clk);
            #1;
            if (Busy) Cap_end = 1'b0;
            if (rd_cnt - rd0 == 2) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rstmid_reach timeout waiting for second read");
        end
        #2 Reset_n = 1'b0;
        #1;
        check_outputs_zero("rstmid");
        void'(model_q.pop_front());
        void'(model_q.pop_front());
        Cap_end = 1'b0;
        wait_cyc(2);
        Reset_n = 1'b1;
        wait_cyc(1);
        run_frame("after_rst", 100, 1'b0);
    endtask

    task automatic test_random();
        int k;
        for (int f = 0; f < 6; f++) begin
            k = $urandom_range(0, 6);
            for (int i = 0; i < k; i++) push_sample(10'($urandom));
            run_frame($sformatf("rand%0d", f), 60, 1'b0);
        end
        total++;
        if (stab_err != 0) begin
            bad++;
            $display("FAIL stability violations got=%0d exp=0", stab_err);
        end
        total++;
        if (empty_rd_err != 0) begin
            bad++;
            $display("FAIL rdreq_on_empty got=%0d exp=0", empty_rd_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_empty();
        test_max();
        test_cap_hold();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/capture_readout.md
Name: capture_readout

Overview:
- Drains the ADC0 capture FIFO once a capture completes, framing samples into a byte stream on a valid/ready interface for the host link (UART/USB bridge).
- Sits between the ADC0 capture driver (FIFO read side, done/re-arm strobes) and the host transmitter.
- Replaces ad-hoc rdreq logic in the top level.
- Re-arms the capture driver after each frame.

Parameters:
- DATA_W, 10: ADC sample width. Must be 9..16. Packed into 2 bytes.
- MAX_SAMPLES, 1024: max samples read per frame.
- CNT_W, 11: sample counter width. Must satisfy 2^CNT_W > MAX_SAMPLES and CNT_W <= 16.
- HDR0, 8'hA5: first header byte.
- HDR1, 8'h5A: second header byte.

Ports:
- Clk  in  1  system clock; all logic on posedge.
- Reset_n  in  1  asynchronous active-low reset.
- Cap_end  in  1  capture-done level from the capture driver.
- Fifo_empty  in  1  capture FIFO empty flag.
- Fifo_data  in  DATA_W  FIFO q. Normal mode: valid 1 cycle after rdreq.
- Fifo_rdreq  out  1  FIFO read strobe, 1-cycle pulse per sample.
- Cap_bg  out  1  re-arm pulse to the capture driver.
- Tx_data  out  8  stream byte.
- Tx_valid  out  1  byte valid.
- Tx_ready  in  1  sink accepts byte.
- Busy  out  1  high from frame start until WAIT_CLR exit.
- Frame_done  out  1  1-cycle pulse when the last frame byte is accepted.

Behaviour:
- Reset values: Fifo_rdreq, Cap_bg, Tx_valid, Busy, Frame_done = 0; Tx_data = 0. Counter and checksum cleared; state IDLE.
- Reset mid-frame: abort immediately, drop the partial frame, leave FIFO contents unflushed.
- Transfer rule: a byte transfers on a posedge with Tx_valid && Tx_ready. Tx_data must stay stable while Tx_valid=1 and Tx_ready=0. Tx_valid never drops without a transfer.
- Frame format: HDR0, HDR1, then per sample {zero-pad, d[DATA_W-1:8]} followed by d[7:0], then CNT_HI, CNT_LO, then [CHK].
  - CNT = samples actually read, zero-extended to 16 bits.
- FSM states:
  - IDLE: Cap_end=1 -> HDR.
  - HDR: send HDR0, HDR1 -> RD.
  - RD: if !Fifo_empty && cnt<MAX_SAMPLES, pulse Fifo_rdreq, then -> LATCH; else -> TRL.
  - LATCH: register Fifo_data; cnt++ -> TX_HI.
  - TX_HI -> TX_LO -> RD.
  - TRL: send count bytes (and CHK) -> REARM.
  - REARM: Cap_bg=1 for exactly 1 cycle; Frame_done pulses in the same cycle -> WAIT_CLR.
  - WAIT_CLR: wait for Cap_end=0 -> IDLE. This prevents a stale done level from re-triggering.
- Read rules:
  - At most one outstanding read; rdreq is never asserted while Fifo_empty=1.
  - Empty sampled in RD ends the frame (short frame); an empty capture yields CNT=0.
  - Stop at MAX_SAMPLES even if the FIFO is not empty; the remainder stays in the FIFO.
- Byte latency: first header byte has Tx_valid on the cycle after IDLE sees Cap_end. Each following byte is presented the cycle after the previous transfer, except 2 extra cycles (RD, LATCH) per sample.
- Cap_end dropping mid-frame has no effect; the frame completes.

Optional Feature:
- READOUT_CHECKSUM_EN defined:
  - A trailing CHK byte is sent.
  - CHK = 8-bit modulo-256 sum of all payload and count bytes, excluding the header.
- Not defined: no CHK byte, and no checksum register.

Decomposition:
- Package capture_readout_pkg holds:
  - state enum;
  - HDR defaults;
  - function pack_hi(sample) returning the upper byte zero-padded.
- One natural sub-module, readout_tx_stage: an output holding register implementing the valid/ready stability rule. The FSM loads a byte and waits for its accept.

Test Plan:
- FIFO holds 3FF, 000, 155; pulse Cap_end; Tx_ready=1 -> bytes A5 5A 03 FF 00 00 01 55 00 03 5B (5B only with checksum). Exactly 3 rdreq pulses; 1 Cap_bg pulse.
- Empty FIFO, Cap_end=1 -> A5 5A 00 00 [00]. No rdreq; Cap_bg pulses once.
- MAX_SAMPLES=4, FIFO holds 6 samples -> CNT bytes 00 04, 4 rdreq pulses, Fifo_empty still 0 after the frame.
- Tx_ready low 5 cycles during a TX_LO byte -> Tx_data/Tx_valid constant, no rdreq issued, stream resumes with the next byte.
- Cap_end held high after the frame -> no second frame until Cap_end goes 0 then 1. Then a new frame starts with A5.
- Reset_n low during sample 2 -> all outputs 0 asynchronously. After release, Cap_end=1 starts a fresh frame from A5 with count restarting at 0.
